// File: rtl/data_memory_port.sv
// data_memory_port: load/store front end for the data RAM.
// One byte-addressed request per cycle over valid/ready, fixed one-cycle
// response latency, byte-lane steering for stores, load alignment and
// sign/zero extension, and fault flagging for misaligned or out-of-range
// accesses.

package data_memory_port_pkg;
   typedef enum logic [1:0] {
      write_byte     = 2'd0,
      write_halfword = 2'd1,
      write_word     = 2'd2
   } write_width_t;
endpackage

// state        | meaning
// -------------+-------------------------------------------------
// s_idle       | no response pending
// s_resp_load  | load response pending, RAM read data on resp_rdata
// s_resp_store | store response pending, resp_rdata = 0
// s_resp_fault | faulted request pending, resp_fault = 1
module data_memory_port
   import data_memory_port_pkg::*;
#(
   parameter  int LOG_MEM_SIZE_WORDS = 14,
   localparam int XLEN               = 32
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [XLEN-1:0]   req_addr,
   input  write_width_t      req_width,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault
);

   localparam int MEM_WORDS = 1 << LOG_MEM_SIZE_WORDS;

   typedef enum logic [1:0] {
      s_idle,
      s_resp_load,
      s_resp_store,
      s_resp_fault
   } state_t;

   state_t state, state_nxt;

   logic [31:0] mem [MEM_WORDS];

   logic                          accept;
   logic                          retire;
   logic                          fault;
   logic [LOG_MEM_SIZE_WORDS-1:0] word_idx;
   logic [LOG_MEM_SIZE_WORDS-1:0] rd_addr;
   logic [LOG_MEM_SIZE_WORDS-1:0] rd_addr_q;
   logic [1:0]                    off;
   logic [3:0]                    be;
   logic [31:0]                   wdata_lanes;
   logic [31:0]                   rd_word;
   logic [31:0]                   shifted;
   logic [31:0]                   load_data;
   logic [1:0]                    off_q;
   write_width_t                  width_q;
   logic                          unsigned_q;

   assign off        = req_addr[1:0];
   assign word_idx   = req_addr[LOG_MEM_SIZE_WORDS+1:2];
   assign req_ready  = !reset && (state == s_idle || resp_ready);
   assign accept     = req_valid && req_ready;
   // Outputs are gated by reset so a pending response vanishes immediately.
   assign resp_valid = !reset && (state != s_idle);
   assign retire     = resp_valid && resp_ready;

   // Fault detection, byte enables and store lane replication.
   always_comb begin
      fault       = |req_addr[XLEN-1:LOG_MEM_SIZE_WORDS+2];
      be          = 4'b1111;
      wdata_lanes = req_wdata;
      case (req_width)
         write_byte: begin
            be          = 4'b0001 << off;
            wdata_lanes = {4{req_wdata[7:0]}};
         end
         write_halfword: begin
            if (off[0]) fault = 1'b1;
            be          = 4'b0011 << off;
            wdata_lanes = {2{req_wdata[15:0]}};
         end
         default: begin
            if (off != 2'b00) fault = 1'b1;
         end
      endcase
   end

   // Byte-enabled RAM write; faulting stores never reach the array.
   always_ff @(posedge clock) begin
      if (accept && req_write && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
         end
      end
   end

   // Read address follows a newly accepted load, otherwise stays on the last
   // load's word so the read data is stable while the response waits.
   assign rd_addr = (accept && !req_write) ? word_idx : rd_addr_q;

   // Synchronous RAM read port.
   always_ff @(posedge clock) begin
      rd_word <= mem[rd_addr];
   end

   // Capture the accepted load's address, offset, width and extension mode.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_addr_q  <= '0;
         off_q      <= 2'b00;
         width_q    <= write_word;
         unsigned_q <= 1'b0;
      end else if (accept && !req_write) begin
         rd_addr_q  <= word_idx;
         off_q      <= off;
         width_q    <= req_width;
         unsigned_q <= req_unsigned;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= s_idle;
      else       state <= state_nxt;
   end

   // Next state: a new accept wins, a bare retire returns to idle.
   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (fault)          state_nxt = s_resp_fault;
         else if (req_write) state_nxt = s_resp_store;
         else                state_nxt = s_resp_load;
      end else if (retire) begin
         state_nxt = s_idle;
      end
   end

   // Load alignment, truncation and extension; response data/fault outputs.
   always_comb begin
      shifted   = rd_word >> {off_q, 3'b000};
      load_data = shifted;
      case (width_q)
         write_byte:     load_data = {{24{!unsigned_q && shifted[7]}}, shifted[7:0]};
         write_halfword: load_data = {{16{!unsigned_q && shifted[15]}}, shifted[15:0]};
         default:        load_data = shifted;
      endcase
      resp_rdata = (resp_valid && state == s_resp_load) ? load_data : '0;
      resp_fault = resp_valid && (state == s_resp_fault);
   end

endmodule

// File: tb/tb_data_memory_port.sv
// Scoreboard bench for data_memory_port: a byte-array memory model produces
// the expected response at accept time; a negedge monitor retires responses
// against the queue and checks latency, hold stability and reset behaviour.
module tb_data_memory_port;
   import data_memory_port_pkg::*;

   localparam int LOGW  = 4;
   localparam int BYTES = 4 << LOGW;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_write = 1'b0;
   logic         req_unsigned = 1'b0;
   logic         resp_ready = 1'b1;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_wdata = '0;
   write_width_t req_width = write_word;
   logic         req_ready;
   logic         resp_valid;
   logic         resp_fault;
   logic [31:0]  resp_rdata;

   data_memory_port #(.LOG_MEM_SIZE_WORDS(LOGW)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_width    (req_width),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   logic [7:0] ref_mem [BYTES];
   exp_t       exp_q[$];
   int         bp_mode = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   // Reference model: memory as a flat byte array, little-endian.
   function automatic exp_t model(input logic wr, input logic [31:0] a,
                                  input write_width_t w, input logic uns,
                                  input logic [31:0] wd);
      int          n;
      exp_t        e;
      logic [31:0] v;
      n = (w == write_byte) ? 1 : (w == write_halfword) ? 2 : 4;
      e.rdata = '0;
      e.fault = (a >= BYTES) || ((a % n) != 0);
      if (e.fault) return e;
      if (wr) begin
         for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
         return e;
      end
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
      if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      e.rdata = v;
      return e;
   endfunction

   // resp_ready driver
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard
   logic        acc_prev = 1'b0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_d;
   logic        hold_f;

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         check1("reset_req_ready", req_ready, 1'b0);
         check1("reset_resp_valid", resp_valid, 1'b0);
         check1("reset_resp_fault", resp_fault, 1'b0);
         check32("reset_resp_rdata", resp_rdata, 32'h0);
         exp_q.delete();
         acc_prev = 1'b0;
         hold_v   = 1'b0;
      end else begin
         if (acc_prev) check1("latency_resp_valid", resp_valid, 1'b1);
         if (hold_v) begin
            check1("hold_resp_valid", resp_valid, 1'b1);
            check32("hold_resp_rdata", resp_rdata, hold_d);
            check1("hold_resp_fault", resp_fault, hold_f);
            hold_v = 1'b0;
         end
         if (resp_valid) begin
            if (resp_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_resp: got resp_valid 1 expected 0");
               end else begin
                  e = exp_q.pop_front();
                  check32("resp_rdata", resp_rdata, e.rdata);
                  check1("resp_fault", resp_fault, e.fault);
               end
            end else begin
               hold_v = 1'b1;
               hold_d = resp_rdata;
               hold_f = resp_fault;
            end
         end
         acc_prev = req_valid && req_ready;
         if (acc_prev) exp_q.push_back(model(req_write, req_addr, req_width, req_unsigned, req_wdata));
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a, input write_width_t w,
                        input logic uns, input logic [31:0] wd, output int waited);
      logic ok;
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = a;
      req_width    = w;
      req_unsigned = uns;
      req_wdata    = wd;
      waited       = 0;
      ok           = 1'b0;
      while (!ok) begin
         @(negedge clock);
         ok = req_ready;
         @(posedge clock);
         #1;
         if (!ok) begin
            waited++;
            if (waited > 100) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", waited);
               ok = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           w;
      write_width_t wr_w;
      for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < BYTES / 4; i++) issue(1'b1, 32'(i * 4), write_word, 1'b0, $urandom, w);

      issue(1'b1, 32'h10, write_word, 1'b0, 32'hDEADBEEF, w);
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      issue(1'b1, 32'h13, write_byte, 1'b0, 32'h00000011, w);
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h12, write_byte, 1'b0, 32'h0, w);
      issue(1'b0, 32'h12, write_byte, 1'b1, 32'h0, w);
      issue(1'b0, 32'h12, write_halfword, 1'b0, 32'h0, w);
      issue(1'b0, 32'h11, write_halfword, 1'b0, 32'h0, w);
      issue(1'b1, 32'h12, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      issue(1'b1, 32'h40, write_word, 1'b0, 32'h12345678, w);
      issue(1'b1, 32'h3C, write_word, 1'b0, 32'hA5A55A5A, w);
      issue(1'b0, 32'h3C, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h00, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h0E, write_halfword, 1'b1, 32'h0, w);
      idle(2);

      // Backpressure: pending load blocks a new request for 3 cycles.
      bp_mode    = 2;
      resp_ready = 1'b0;
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h14;
      req_width = write_word;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check1("backpressure_req_ready", req_ready, 1'b0);
         @(posedge clock);
         #1;
      end
      bp_mode    = 0;
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue(1'b0, 32'(32'h14 + 4 * k), write_word, 1'b0, 32'h0, w);
         check32("throughput_wait", 32'(w), 32'h0);
      end
      idle(2);

      // Randomized traffic with random backpressure.
      bp_mode = 1;
      repeat (300) begin
         case ($urandom_range(0, 2))
            0:       wr_w = write_byte;
            1:       wr_w = write_halfword;
            default: wr_w = write_word;
         endcase
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, BYTES + 7)), wr_w,
               1'($urandom_range(0, 1)), $urandom, w);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      bp_mode = 0;
      idle(4);

      // Reset while a load response is pending; a store is presented during reset.
      bp_mode    = 2;
      resp_ready = 1'b0;
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      reset     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0;
      req_width = write_word;
      req_wdata = 32'hCAFEF00D;
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      bp_mode    = 0;
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      reset      = 1'b0;
      @(negedge clock);
      check1("reset_dropped_resp", resp_valid, 1'b0);
      @(posedge clock);
      #1;
      issue(1'b0, 32'h00, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h10, write_word, 1'b0, 32'h0, w);
      issue(1'b0, 32'h3C, write_word, 1'b0, 32'h0, w);
      idle(5);

      check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
